// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit driving the HI/LO register write port.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division on operand magnitudes.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [1:0]       wen,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]     a_mag_in, b_mag_in;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_sub;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH-1:0]     quo, rem;

  assign sgn_in   = ~op[0];
  assign a_neg_in = sgn_in & src_a[WIDTH-1];
  assign b_neg_in = sgn_in & src_b[WIDTH-1];
  assign a_mag_in = a_neg_in ? -src_a : src_a;
  assign b_mag_in = b_neg_in ? -src_b : src_b;

  // Multiply: accumulator low half holds the remaining multiplier bits.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: low half shifts the dividend out into the remainder, quotient bits in.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = rem_sh >= {1'b0, b_q};
  assign rem_sub  = rem_sh[WIDTH-1:0] - b_q;
  assign div_next = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign prod_neg = -acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          state_d = S_CALC;
          cnt_d   = '0;
          div_d   = op[1];
          neg_a_d = a_neg_in;
          neg_b_d = b_neg_in;
          a_d     = a_mag_in;
          b_d     = b_mag_in;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, a_mag_in} : {{WIDTH{1'b0}}, b_mag_in};
        end
      end
      S_CALC: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_SIGN;
      end
      S_SIGN: begin
        state_d = S_DONE;
        if (!div_q) begin
          {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : acc_q;
        end else if (b_q == '0) begin
          // Divide by zero: hand back the original dividend, all-ones quotient.
          hi_d = neg_a_q ? -a_q : a_q;
          lo_d = '1;
        end else begin
          hi_d = neg_a_q ? -rem : rem;
          lo_d = (neg_a_q ^ neg_b_q) ? -quo : quo;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) && !cancel;
  assign wen      = {2{done}};
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, cycle-exact latency,
// cancel, start-while-busy and asynchronous reset behaviour.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        busy, done;
  logic [1:0]  wen;
  logic [31:0] hi_wdata, lo_wdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned wen_seen = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .wen      (wen),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wen !== 2'b00) wen_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start in cycle 0, check busy over cycles 1..34, the beat in cycle 34, idle in 35.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit poke);
    int unsigned bcnt = 0;
    int unsigned dcnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    chk({tag, ".busy_c1"}, busy, 1'b1);
    for (int c = 2; c <= 33; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done || wen != 2'b00) dcnt++;
      if (poke && c == 4) begin
        start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
      end
      if (poke && c == 6) start = 1'b0;
    end
    chk({tag, ".busy_c2_33"}, bcnt, 32);
    chk({tag, ".early_beat"}, dcnt, 0);
    @(negedge clk);
    chk({tag, ".busy_c34"}, busy, 1'b1);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".wen"}, wen, 2'b11);
    chk({tag, ".hi"}, hi_wdata, eh);
    chk({tag, ".lo"}, lo_wdata, el);
    @(negedge clk);
    chk({tag, ".idle_c35"}, {busy, done, wen}, 4'b0000);
  endtask

  initial begin
    int unsigned w0;
    resetn = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; cancel = 1'b0;
    #12;
    chk("reset.outs", {busy, done, wen}, 4'b0000);
    chk("reset.hilo", {hi_wdata, lo_wdata}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_pos", OP_MULT, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0);
    run_op("mult_neg_neg", OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // Cancel in cycle 10 of a DIVU, then MULTU 3x5 started in cycle 11.
    w0 = wen_seen;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    chk("cancel.busy_c11", busy, 1'b0);
    chk("cancel.hilo_kept", {hi_wdata, lo_wdata}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("cancel.no_beat", wen_seen, w0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (33) @(negedge clk);
    chk("restart.pre_c44", {done, wen}, 3'b000);
    @(negedge clk);
    chk("restart.beat_c45", {done, wen}, 3'b111);
    chk("restart.hilo", {hi_wdata, lo_wdata}, {32'd0, 32'd15});

    // Start while busy must not disturb the in-flight DIVU.
    run_op("poke_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

    // Cancel held during the DONE cycle masks the beat.
    w0 = wen_seen;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (33) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    chk("cancel_done.beat", {done, wen}, 3'b000);
    chk("cancel_done.busy", busy, 1'b1);
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_done.idle", busy, 1'b0);
    chk("cancel_done.no_beat", wen_seen, w0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    chk("areset.pre_busy", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("areset.outs", {busy, done, wen}, 4'b0000);
    chk("areset.hilo", {hi_wdata, lo_wdata}, 64'd0);
    w0 = wen_seen;
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("areset.no_stale_beat", wen_seen, w0);
    chk("areset.idle", busy, 1'b0);

    run_op("post_reset", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO write traffic for the CPU core's HI/LO register pair. It accepts a MULT/MULTU/DIV/DIVU request from the execute stage and computes a 64-bit result over a fixed number of cycles. It then presents one write beat (`hi_wdata`, `lo_wdata`, `wen`) that drives the HI/LO register write port directly. `busy` is the pipeline stall source while an operation is in flight.

## Interface
- `WIDTH`, 32: operand width; the result is 2×WIDTH. Only 32 is verified.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: request valid; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a` in 32: multiplicand / dividend (rs).
- `src_b` in 32: multiplier / divisor (rt).
- `cancel` in 1: exception/flush; aborts the operation in flight.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: one-cycle pulse, coincident with the write beat.
- `wen` out 2: [1] writes HI, [0] writes LO. Value is 2'b11 on the write beat, 0 otherwise.
- `hi_wdata` out 32: product[63:32] or remainder.
- `lo_wdata` out 32: product[31:0] or quotient.

## Operation
- FSM states: IDLE, CALC, SIGN, DONE.
- **IDLE**
  - On `start && !cancel`, latch `op` and the sign flags, and latch |src_a|, |src_b|. Magnitudes apply only for signed ops; unsigned ops take the raw value. Clear the count; go to CALC.
  - `start` while busy is ignored; the requester holds it until `busy` is low.
- **CALC**: one iteration per cycle, 32 iterations, count 0..31. At count==31 go to SIGN.
  - Multiply: radix-2 shift-add on a 64-bit accumulator. If the current multiplier LSB is 1, add the multiplicand into the upper half with a 33-bit carry. Then shift the accumulator right by 1.
  - Divide: restoring. Shift {rem, quo} left by 1 with the dividend MSB entering rem. If rem >= divisor, subtract the divisor and set quo LSB to 1.
- **SIGN**: fix-up and register the result into the `hi_wdata`/`lo_wdata` registers; go to DONE.
  - MULT: negate the 64-bit product (two's complement) iff sign(a) != sign(b).
  - DIV: negate the quotient iff the signs differ; negate the remainder iff the dividend is negative.
  - Unsigned ops: no fix-up.
- **DONE**: `wen`=2'b11 and `done`=1 for exactly this cycle; then IDLE.
- Divide by zero (DIV or DIVU, src_b==0): latency unchanged, sign fix-up suppressed. Result is hi=src_a (original value), lo=32'hFFFF_FFFF.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. This falls out of the magnitude datapath and needs no special case.
- `cancel` in any state forces IDLE on the next edge with no write beat.
  - In DONE, `cancel` masks `wen` and `done` combinationally in the same cycle.
  - `cancel` together with `start` in IDLE: start is ignored.
- `op`, `src_a` and `src_b` are don't-care after the start cycle; only latched copies are used.

## Timing
- Reset (asynchronous, resetn=0): state=IDLE. `busy`=0, `done`=0, `wen`=0, `hi_wdata`=0, `lo_wdata`=0. Counter and datapath registers are cleared.
- Reset asserted mid-operation: the operation is discarded immediately and no write beat is issued.
- Start accepted at cycle 0 (edge at the end of cycle 0):
  - CALC occupies cycles 1–32.
  - SIGN is cycle 33.
  - DONE (write beat) is cycle 34.
  - `busy` is high for cycles 1–34 and low in cycle 35, when the next start can be accepted.
- Back-to-back: the minimum start-to-start spacing is 35 cycles.
- `hi_wdata`/`lo_wdata` are registered. They hold their last result until the next SIGN, and are not cleared by `cancel`.
- Fixed latency is required; there is no early termination.

## Test plan
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF, start at cycle 0 -> cycle 34: wen=2'b11, done=1, hi=32'hFFFF_FFFE, lo=32'h0000_0001. busy=1 for cycles 1–34.
- MULT -3 × 7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU 7 / 0 -> hi=32'h0000_0007, lo=32'hFFFF_FFFF at cycle 34. DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- `cancel` pulsed in cycle 10 of a DIVU -> busy=0 from cycle 11, no wen/done pulse. A new MULTU 3×5 started in cycle 11 -> lo=15, hi=0 at cycle 45.
- `cancel` held in the DONE cycle -> wen=0, done=0, FSM returns to IDLE. `start` while busy is ignored, with no effect on the in-flight result.
- resetn deasserted asynchronously mid-CALC -> all outputs 0 without a clock edge. After release, no stale write beat occurs.
